// File: rtl/fp_class_pipe_if.sv
// Handshake/data bundle for the floating-point classify pipeline.
// master = operand producer / result consumer, slave = classify unit.
interface fp_class_pipe_if #(
    parameter int TAG_W = 5
) ();
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      data1;
    logic [1:0]       fmt;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      result;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    modport master (
        output in_valid, data1, fmt, in_tag, out_ready,
        input  in_ready, out_valid, result, out_tag, busy
    );

    modport slave (
        input  in_valid, data1, fmt, in_tag, out_ready,
        output in_ready, out_valid, result, out_tag, busy
    );
endinterface

// File: rtl/fp_class_pipe.sv
// Two-stage FCLASS.S / FCLASS.D unit: S1 decodes the IEEE fields, S2 encodes
// the one-hot class mask. Full backpressure, results in order.
// Build option FP_NANBOX_CHECK_EN: a single-precision operand whose upper word
// is not all ones (not NaN-boxed) classifies as the canonical quiet NaN.
module fp_class_pipe #(
    parameter int TAG_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,   // active-high despite the name
    fp_class_pipe_if.slave     io_bus
);

    logic             r_s1_valid;
    logic             r_s1_sign;
    logic             r_s1_exp_ones;
    logic             r_s1_exp_zero;
    logic             r_s1_man_zero;
    logic             r_s1_quiet;
    logic             r_s1_fmt_ok;
    logic [TAG_W-1:0] r_s1_tag;

    logic             r_s2_valid;
    logic [9:0]       r_s2_mask;
    logic [TAG_W-1:0] r_s2_tag;

    logic             w_s2_adv;
    logic             w_s1_adv;
    logic             w_in_xfer;
    logic             w_sign;
    logic             w_exp_ones;
    logic             w_exp_zero;
    logic             w_man_zero;
    logic             w_quiet;
    logic             w_fmt_ok;
    logic [9:0]       w_mask;

    assign w_s2_adv  = !r_s2_valid || io_bus.out_ready;
    assign w_s1_adv  = !r_s1_valid || w_s2_adv;
    assign w_in_xfer = io_bus.in_valid && w_s1_adv;

    assign io_bus.in_ready  = w_s1_adv;
    assign io_bus.out_valid = r_s2_valid;
    assign io_bus.result    = {54'd0, r_s2_mask};
    assign io_bus.out_tag   = r_s2_tag;
    assign io_bus.busy      = r_s1_valid || r_s2_valid;

    // Field decode of the presented operand for the selected format.
    always_comb begin
        w_sign     = 1'b0;
        w_exp_ones = 1'b0;
        w_exp_zero = 1'b0;
        w_man_zero = 1'b0;
        w_quiet    = 1'b0;
        w_fmt_ok   = 1'b0;
        case (io_bus.fmt)
            2'd0: begin
                w_sign     = io_bus.data1[31];
                w_exp_ones = &io_bus.data1[30:23];
                w_exp_zero = ~|io_bus.data1[30:23];
                w_man_zero = ~|io_bus.data1[22:0];
                w_quiet    = io_bus.data1[22];
                w_fmt_ok   = 1'b1;
`ifdef FP_NANBOX_CHECK_EN
                // Improperly boxed single: force the canonical qNaN fields.
                if (!(&io_bus.data1[63:32])) begin
                    w_sign     = 1'b0;
                    w_exp_ones = 1'b1;
                    w_exp_zero = 1'b0;
                    w_man_zero = 1'b0;
                    w_quiet    = 1'b1;
                end
`endif
            end
            2'd1: begin
                w_sign     = io_bus.data1[63];
                w_exp_ones = &io_bus.data1[62:52];
                w_exp_zero = ~|io_bus.data1[62:52];
                w_man_zero = ~|io_bus.data1[51:0];
                w_quiet    = io_bus.data1[51];
                w_fmt_ok   = 1'b1;
            end
            default: ;
        endcase
    end

    // S1 register: valid flag plus decoded fields, loaded on an input transfer.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_s1_valid    <= 1'b0;
            r_s1_sign     <= 1'b0;
            r_s1_exp_ones <= 1'b0;
            r_s1_exp_zero <= 1'b0;
            r_s1_man_zero <= 1'b0;
            r_s1_quiet    <= 1'b0;
            r_s1_fmt_ok   <= 1'b0;
            r_s1_tag      <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= io_bus.in_valid;
            if (w_in_xfer) begin
                r_s1_sign     <= w_sign;
                r_s1_exp_ones <= w_exp_ones;
                r_s1_exp_zero <= w_exp_zero;
                r_s1_man_zero <= w_man_zero;
                r_s1_quiet    <= w_quiet;
                r_s1_fmt_ok   <= w_fmt_ok;
                r_s1_tag      <= io_bus.in_tag;
            end
        end
    end

    // Class mask encode from the S1 fields; unsupported formats yield zero.
    always_comb begin
        w_mask = 10'd0;
        if (r_s1_fmt_ok) begin
            if (r_s1_exp_ones) begin
                if (r_s1_man_zero)   w_mask[r_s1_sign ? 0 : 7] = 1'b1;
                else if (r_s1_quiet) w_mask[9] = 1'b1;
                else                 w_mask[8] = 1'b1;
            end else if (r_s1_exp_zero) begin
                if (r_s1_man_zero)   w_mask[r_s1_sign ? 3 : 4] = 1'b1;
                else                 w_mask[r_s1_sign ? 2 : 5] = 1'b1;
            end else begin
                w_mask[r_s1_sign ? 1 : 6] = 1'b1;
            end
        end
    end

    // S2 register: result holds under backpressure and clears when drained.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_mask  <= 10'd0;
            r_s2_tag   <= '0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            r_s2_mask  <= r_s1_valid ? w_mask : 10'd0;
            r_s2_tag   <= r_s1_valid ? r_s1_tag : '0;
        end
    end

endmodule

// File: tb/tb_fp_class_pipe.sv
// Directed bench for fp_class_pipe with a scoreboard queue of expected results.
module tb_fp_class_pipe;

    typedef struct packed {
        logic [4:0]  tag;
        logic [63:0] res;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   cyc;
    int   xfer_cyc;
    exp_t exp_q[$];
    int   out_cyc_q[$];

    fp_class_pipe_if #(.TAG_W(5)) bus ();

    fp_class_pipe #(.TAG_W(5)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Output monitor: pop and compare on every output transfer.
    always @(negedge clk) begin
        exp_t e;
        if (!bus.out_valid) check("empty_result_zero", bus.result, 64'd0);
        if (!rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("result", bus.result, e.res);
                check("out_tag", {59'd0, bus.out_tag}, {59'd0, e.tag});
                out_cyc_q.push_back(cyc);
            end
        end
    end

    // Present an operand at posedge+1 and hold it until accepted.
    task automatic send(input logic [63:0] d, input logic [1:0] f, input logic [4:0] t,
                        input logic [63:0] exp);
        int n;
        bus.in_valid = 1'b1;
        bus.data1    = d;
        bus.fmt      = f;
        bus.in_tag   = t;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 50) check("accept_timeout", 64'd1, 64'd0);
        xfer_cyc = cyc;
        exp_q.push_back('{tag: t, res: exp});
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] nb_exp;
        checks       = 0;
        failures     = 0;
        cyc          = 0;
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        bus.data1    = 64'd0;
        bus.fmt      = 2'd0;
        bus.in_tag   = 5'd0;
        bus.out_ready = 1'b1;

        #2;
        check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_result", bus.result, 64'd0);
        check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        #10 rst_n = 1'b0;
        @(posedge clk); #1;

        // Single 1.0f with latency check
        out_cyc_q.delete();
        send(64'hFFFFFFFF_3F800000, 2'd0, 5'd3, 64'h040);
        drain();
        check("lat_count", 64'(out_cyc_q.size()), 64'd1);
        if (out_cyc_q.size() == 1) check("latency", 64'(out_cyc_q[0] - xfer_cyc), 64'd2);

        // Back-to-back doubles, no bubbles
        out_cyc_q.delete();
        send(64'hFFF0000000000000, 2'd1, 5'd4, 64'h001);
        send(64'h8000000000000000, 2'd1, 5'd5, 64'h008);
        send(64'h000FFFFFFFFFFFFF, 2'd1, 5'd6, 64'h020);
        send(64'h7FF8000000000000, 2'd1, 5'd7, 64'h200);
        drain();
        check("b2b_count", 64'(out_cyc_q.size()), 64'd4);
        if (out_cyc_q.size() == 4) check("b2b_span", 64'(out_cyc_q[3] - out_cyc_q[0]), 64'd3);

        // Single NaNs, unsupported fmt, other classes
        send(64'hFFFFFFFF_7F800001, 2'd0, 5'd8,  64'h100);
        send(64'hFFFFFFFF_FFC00000, 2'd0, 5'd9,  64'h200);
        send(64'h123456789ABCDEF0, 2'd2, 5'd10, 64'h000);
        send(64'hFFFFFFFF_7F800000, 2'd0, 5'd11, 64'h080);
        send(64'hC000000000000000, 2'd1, 5'd12, 64'h002);
        send(64'h0000000000000000, 2'd1, 5'd13, 64'h010);
        send(64'hFFFFFFFF_80000001, 2'd0, 5'd14, 64'h004);
        send(64'h7FF0000000000001, 2'd1, 5'd15, 64'h100);
        send(64'hFFFFFFFF_FF800000, 2'd0, 5'd16, 64'h001);
        send(64'hFFFFFFFF_00000000, 2'd3, 5'd17, 64'h000);
        drain();

        // Backpressure: two accepted, third held
        out_cyc_q.delete();
        bus.out_ready = 1'b0;
        send(64'hFFFFFFFF_3F800000, 2'd0, 5'd20, 64'h040);
        send(64'hBFF0000000000000, 2'd1, 5'd21, 64'h002);
        check("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
        bus.in_valid = 1'b1;
        bus.data1    = 64'h7FF0000000000000;
        bus.fmt      = 2'd1;
        bus.in_tag   = 5'd22;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_held_ready", {63'd0, bus.in_ready}, 64'd0);
            check("bp_out_valid", {63'd0, bus.out_valid}, 64'd1);
            check("bp_result_stable", bus.result, 64'h040);
            check("bp_tag_stable", {59'd0, bus.out_tag}, 64'd20);
            @(posedge clk); #1;
        end
        exp_q.push_back('{tag: 5'd22, res: 64'h080});
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        drain();
        check("bp_count", 64'(out_cyc_q.size()), 64'd3);

        // Async reset with both stages full
        bus.out_ready = 1'b0;
        send(64'hFFFFFFFF_3F800000, 2'd0, 5'd24, 64'h040);
        send(64'hFFFFFFFF_3F800000, 2'd0, 5'd25, 64'h040);
        check("full_busy", {63'd0, bus.busy}, 64'd1);
        check("full_out_valid", {63'd0, bus.out_valid}, 64'd1);
        #2 rst_n = 1'b1;
        #1;
        check("arst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("arst_busy", {63'd0, bus.busy}, 64'd0);
        check("arst_result", bus.result, 64'd0);
        check("arst_tag", {59'd0, bus.out_tag}, 64'd0);
        check("arst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        exp_q.delete();
        @(negedge clk); #1;
        rst_n = 1'b0;
        bus.out_ready = 1'b1;
        check("post_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        @(posedge clk); #1;
        out_cyc_q.delete();
        send(64'h3FF0000000000000, 2'd1, 5'd26, 64'h040);
        drain();
        check("post_rst_count", 64'(out_cyc_q.size()), 64'd1);
        if (out_cyc_q.size() == 1) check("post_rst_latency", 64'(out_cyc_q[0] - xfer_cyc), 64'd2);

        // NaN-box behaviour depends on the build option
`ifdef FP_NANBOX_CHECK_EN
        nb_exp = 64'h200;
`else
        nb_exp = 64'h040;
`endif
        send(64'h00000000_3F800000, 2'd0, 5'd27, nb_exp);
        drain();

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
